// File: rtl/usr_pkg.sv
// Shared types for the serial-in/parallel-out receiver.
// Holds the FSM state enum, the bit-order constants and the shift-register
// mode encoding {s1,s0} used between the top and the shift-register block.
package usr_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic LSB_FIRST = 1'b0;
    localparam logic MSB_FIRST = 1'b1;

    typedef enum logic [1:0] {
        HOLD = 2'b00,
        SHR  = 2'b01,
        SHL  = 2'b10,
        LOAD = 2'b11
    } mode_t;

endpackage

// File: rtl/usr_sipo_rx_if.sv
// Bus bundle for usr_sipo_rx.
// master: serial source / word consumer (drives sin, sen, dir, abort,
//         pout_ready, clr_ovf; observes pout, pout_valid, busy, bit_cnt, ovf).
// slave : the receiver itself.
interface usr_sipo_rx_if #(
    parameter int unsigned WIDTH = 4
) ();
    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic             sin;
    logic             sen;
    logic             dir;
    logic             abort;
    logic             pout_ready;
    logic             clr_ovf;
    logic [WIDTH-1:0] pout;
    logic             pout_valid;
    logic             busy;
    logic [CW-1:0]    bit_cnt;
    logic             ovf;

    modport master (
        output sin, sen, dir, abort, pout_ready, clr_ovf,
        input  pout, pout_valid, busy, bit_cnt, ovf
    );

    modport slave (
        input  sin, sen, dir, abort, pout_ready, clr_ovf,
        output pout, pout_valid, busy, bit_cnt, ovf
    );
endinterface

// File: rtl/usr_rx_shreg.sv
// Bit-placement block: shift register plus received-bit counter.
// Ports: clk, rst (async active-high), mode (HOLD/SHR/SHL/LOAD), sin,
//        word_c (word as it will look after this edge's shift),
//        done_c (this edge samples the last bit of a word), bit_cnt.
// SHR inserts at the MSB so the first bit ends at bit 0 (LSB-first);
// SHL inserts at the LSB so the first bit ends at the MSB (MSB-first).
// LOAD loads an empty word (used for abort).
module usr_rx_shreg
    import usr_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  mode_t            mode,
    input  logic             sin,
    output logic [WIDTH-1:0] word_c,
    output logic             done_c,
    output logic [CW-1:0]    bit_cnt
);

    logic [WIDTH-1:0] sreg;

    // Next shifted value and last-bit detect
    always_comb begin
        word_c = sreg;
        done_c = 1'b0;
        case (mode)
            SHR:     word_c = {sin, sreg[WIDTH-1:1]};
            SHL:     word_c = {sreg[WIDTH-2:0], sin};
            default: word_c = sreg;
        endcase
        done_c = ((mode == SHR) || (mode == SHL)) && (bit_cnt == CW'(WIDTH - 1));
    end

    // Register update; a completed word leaves the register empty for the next one
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg    <= '0;
            bit_cnt <= '0;
        end else begin
            case (mode)
                LOAD: begin
                    sreg    <= '0;
                    bit_cnt <= '0;
                end
                SHR, SHL: begin
                    if (done_c) begin
                        sreg    <= '0;
                        bit_cnt <= '0;
                    end else begin
                        sreg    <= word_c;
                        bit_cnt <= bit_cnt + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/usr_sipo_rx.sv
// Serial-in / parallel-out receiver with selectable bit order.
// Ports: clk, rst (async active-high), bus (usr_sipo_rx_if.slave):
//   in : sin, sen, dir, abort, pout_ready, clr_ovf
//   out: pout, pout_valid, busy, bit_cnt, ovf
// Holds the IDLE/SHIFT FSM, the output word register with its valid/ready
// handshake and the sticky overflow flag; bit placement is in usr_rx_shreg.
module usr_sipo_rx
    import usr_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input logic         clk,
    input logic         rst,
    usr_sipo_rx_if.slave bus
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    state_t           state;
    logic             order;
    logic             busy_q;
    logic [WIDTH-1:0] pout_q;
    logic             pout_valid_q;
    logic             ovf_q;

    logic             cur_order_c;
    mode_t            mode_c;
    logic [WIDTH-1:0] word_c;
    logic             done_c;
    logic [CW-1:0]    bit_cnt;

    // Order comes straight from dir on the first bit, from the latch afterwards
    always_comb begin
        cur_order_c = (state == IDLE) ? bus.dir : order;
        mode_c      = HOLD;
        if (bus.abort) begin
            mode_c = LOAD;
        end else if (bus.sen) begin
            if (cur_order_c == MSB_FIRST) begin
                mode_c = SHL;
            end else begin
                mode_c = SHR;
            end
        end
    end

    usr_rx_shreg #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_shreg (
        .clk     (clk),
        .rst     (rst),
        .mode    (mode_c),
        .sin     (bus.sin),
        .word_c  (word_c),
        .done_c  (done_c),
        .bit_cnt (bit_cnt)
    );

    // FSM, output register and overflow flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            order        <= LSB_FIRST;
            busy_q       <= 1'b0;
            pout_q       <= '0;
            pout_valid_q <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            if (bus.abort) begin
                state  <= IDLE;
                busy_q <= 1'b0;
            end else if (bus.sen) begin
                if (state == IDLE) begin
                    state  <= SHIFT;
                    busy_q <= 1'b1;
                    order  <= bus.dir;
                end else if (done_c) begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            end

            // done_c is never set under abort, so an aborted last bit cannot load
            if (done_c && (!pout_valid_q || bus.pout_ready)) begin
                pout_q       <= word_c;
                pout_valid_q <= 1'b1;
            end else if (pout_valid_q && bus.pout_ready) begin
                pout_valid_q <= 1'b0;
            end

            // Set beats clear when both happen on one edge
            if (done_c && pout_valid_q && !bus.pout_ready) begin
                ovf_q <= 1'b1;
            end else if (bus.clr_ovf) begin
                ovf_q <= 1'b0;
            end
        end
    end

    assign bus.pout       = pout_q;
    assign bus.pout_valid = pout_valid_q;
    assign bus.busy       = busy_q;
    assign bus.bit_cnt    = bit_cnt;
    assign bus.ovf        = ovf_q;

endmodule

// File: tb/tb_usr_sipo_rx.sv
// Self-checking bench for usr_sipo_rx (WIDTH=4).
// Inputs change 2 time units after each rising edge; DUT state is compared
// 1 unit after each rising edge, handshakes are scored on the falling edge.
module tb_usr_sipo_rx;

    localparam int unsigned W  = 4;
    localparam int unsigned CW = $clog2(W + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    usr_sipo_rx_if #(.WIDTH(W)) bus ();

    usr_sipo_rx #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboard of words the consumer should receive, in order
    logic [W-1:0] exp_q[$];

    // Reference model: list of bits of the word in progress plus output state
    logic         m_bits[$];
    logic         m_order = 1'b0;
    logic [W-1:0] m_pout  = '0;
    logic         m_valid = 1'b0;
    logic         m_ovf   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_bits.delete();
        m_order = 1'b0;
        m_pout  = '0;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        exp_q.delete();
    endfunction

    // One clock of stimulus; model predicts the state after the coming edge
    task automatic step(input logic s, input logic sn, input logic d,
                        input logic ab, input logic rdy, input logic clr);
        logic         complete;
        logic         set_ovf;
        logic [W-1:0] word;
        complete = 1'b0;
        set_ovf  = 1'b0;
        word     = '0;
        @(posedge clk);
        #2;
        bus.sin        = s;
        bus.sen        = sn;
        bus.dir        = d;
        bus.abort      = ab;
        bus.pout_ready = rdy;
        bus.clr_ovf    = clr;

        if (ab) begin
            m_bits.delete();
        end else if (sn) begin
            if (m_bits.size() == 0) m_order = d;
            m_bits.push_back(s);
            if (m_bits.size() == int'(W)) begin
                for (int k = 0; k < int'(W); k++) begin
                    if (m_order) word[int'(W) - 1 - k] = m_bits[k];
                    else         word[k] = m_bits[k];
                end
                m_bits.delete();
                complete = 1'b1;
            end
        end

        if (complete) begin
            if (!m_valid || rdy) begin
                m_pout  = word;
                m_valid = 1'b1;
                exp_q.push_back(word);
            end else begin
                set_ovf = 1'b1;
            end
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end

        if (set_ovf)  m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
    endtask

    task automatic idle(input logic rdy, input logic clr);
        step(1'b0, 1'b0, 1'b0, 1'b0, rdy, clr);
    endtask

    // Sends b[0] first
    task automatic send_bits(input logic [7:0] b, input int n, input logic d, input logic rdy);
        for (int i = 0; i < n; i++) step(b[i], 1'b1, d, 1'b0, rdy, 1'b0);
    endtask

    // Asynchronous reset mid-cycle; outputs must clear without a clock edge
    task automatic do_reset();
        #1;
        rst = 1'b1;
        #1;
        check("rst_async_pout",  32'(bus.pout), 0);
        check("rst_async_valid", 32'(bus.pout_valid), 0);
        check("rst_async_busy",  32'(bus.busy), 0);
        check("rst_async_cnt",   32'(bus.bit_cnt), 0);
        check("rst_async_ovf",   32'(bus.ovf), 0);
        model_reset();
        bus.sen = 1'b0; bus.abort = 1'b0; bus.pout_ready = 1'b0; bus.clr_ovf = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    // State monitor
    always @(posedge clk) begin
        #1;
        check("busy",    32'(bus.busy), 32'(m_bits.size() != 0));
        check("bit_cnt", 32'(bus.bit_cnt), 32'(m_bits.size()));
        check("valid",   32'(bus.pout_valid), 32'(m_valid));
        check("pout",    32'(bus.pout), 32'(m_pout));
        check("ovf",     32'(bus.ovf), 32'(m_ovf));
    end

    // Handshake monitor: each accepted word must match the scoreboard head
    always @(negedge clk) begin
        if (!rst && bus.pout_valid && bus.pout_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_word: got %0h expected none (scoreboard empty) at t=%0t",
                         bus.pout, $time);
            end else begin
                check("sb_word", 32'(bus.pout), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        logic [7:0] r;
        bus.sin = 1'b0; bus.sen = 1'b0; bus.dir = 1'b0; bus.abort = 1'b0;
        bus.pout_ready = 1'b0; bus.clr_ovf = 1'b0;
        model_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        check("reset_pout", 32'(bus.pout), 0);
        check("reset_busy", 32'(bus.busy), 0);
        rst = 1'b0;

        // LSB-first 0,1,0,1
        send_bits(8'b0000_1010, 4, 1'b0, 1'b0);
        idle(1'b0, 1'b0);
        check("lsb_word",  32'(bus.pout), 32'h a);
        check("lsb_valid", 32'(bus.pout_valid), 1);
        check("lsb_cnt",   32'(bus.bit_cnt), 0);
        idle(1'b1, 1'b0);
        idle(1'b0, 1'b0);

        // MSB-first 1,0,1,1 with dir toggling after the first bit
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1'b0, 1'b0);
        check("msb_word", 32'(bus.pout), 32'h b);
        idle(1'b1, 1'b0);

        // Overflow: second word dropped while first is held
        send_bits(8'b0000_1010, 4, 1'b0, 1'b0);
        send_bits(8'b0000_0110, 4, 1'b0, 1'b0);
        idle(1'b0, 1'b0);
        check("ovf_keep", 32'(bus.pout), 32'h a);
        check("ovf_set",  32'(bus.ovf), 1);
        idle(1'b0, 1'b1);
        idle(1'b0, 1'b0);
        check("ovf_clr", 32'(bus.ovf), 0);
        idle(1'b1, 1'b0);

        // Back-to-back words with ready held high
        for (int w = 0; w < 4; w++) begin
            r = 8'($urandom);
            send_bits(r, 4, 1'($urandom), 1'b1);
        end
        idle(1'b1, 1'b0);
        check("b2b_ovf", 32'(bus.ovf), 0);

        // Abort discards partial word
        send_bits(8'($urandom), 2, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        send_bits(8'b0000_0011, 4, 1'b0, 1'b0);
        idle(1'b0, 1'b0);
        check("abort_word", 32'(bus.pout), 32'h 3);
        idle(1'b1, 1'b0);

        // Reset with a held word and a partial word in flight
        send_bits(8'b0000_0101, 4, 1'b0, 1'b0);
        send_bits(8'b0000_0111, 3, 1'b0, 1'b0);
        do_reset();
        send_bits(8'b0000_1001, 4, 1'b0, 1'b0);
        idle(1'b0, 1'b0);
        check("post_rst_word", 32'(bus.pout), 32'h 9);
        idle(1'b1, 1'b0);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            step(1'($urandom), ($urandom_range(0, 9) < 7), 1'($urandom),
                 ($urandom_range(0, 19) == 0), 1'($urandom),
                 ($urandom_range(0, 9) == 0));
        end

        repeat (3) idle(1'b1, 1'b0);
        check("sb_drained", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
